// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, byte FIFO,
// and a start/data/stop serialiser with a registered tx output.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_write,
  input  logic [31:0] mem_write_data,
  output logic        hit,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];

  logic sel_data, sel_stat, full, empty, busy, push, drop, pop;
  logic unused_wdata;

  assign unused_wdata = ^mem_write_data[31:8];

  // Register decode and combinational read path
  always_comb begin
    sel_data  = (mem_address == BASE_ADDR);
    sel_stat  = (mem_address == STAT_ADDR);
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    busy      = (state_q != IDLE);
    hit       = sel_data | sel_stat;
    read_data = '0;
    if (sel_stat) begin
      read_data = {16'h0000, 8'(count_q), 4'h0, ovf_q, busy, empty, full};
    end
    push = mem_write & sel_data & ~full;
    drop = mem_write & sel_data & full;
  end

  // Serialiser next state; pops the FIFO head when a frame starts
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          tmr_d   = TMR_LOAD;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tmr_q == '0) begin
          tmr_d   = TMR_LOAD;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tmr_q == '0) begin
          tmr_d = TMR_LOAD;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tmr_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            tmr_d   = TMR_LOAD;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = mem_write_data[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (mem_write && sel_stat) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic        hit;
  logic [31:0] read_data;
  logic        tx;

  int errors = 0;
  int checks = 0;
  logic [255:0] wave;
  int wn;
  logic [31:0] st;
  logic [255:0] exp_w;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_address   (mem_address),
    .mem_write     (mem_write),
    .mem_write_data(mem_write_data),
    .hit           (hit),
    .read_data     (read_data),
    .tx            (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      wave[wn] = tx;
      wn++;
    end
  endtask

  task automatic read_status(output logic [31:0] v);
    mem_address = BASE + 32'd4;
    #1;
    v = read_data;
    mem_address = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wave(input string tag, input int n, input logic [255:0] exp);
    logic [255:0] obs;
    obs = '0;
    for (int i = 0; i < n; i++) obs[i] = wave[i];
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected tx level for each of the 40 cycles of one frame, index = cycle
  function automatic logic [39:0] frame(input logic [7:0] b);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      if (i < CPB)           f[i] = 1'b0;
      else if (i < 9 * CPB)  f[i] = b[(i - CPB) / CPB];
      else                   f[i] = 1'b1;
    end
    return f;
  endfunction

  initial begin
    rst = 1'b0;
    mem_address = 32'h0;
    mem_write = 1'b0;
    mem_write_data = 32'h0;
    wave = '0;
    wn = 0;

    // Reset
    tick();
    tick();
    rst = 1'b1;
    chk("reset_tx", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("reset_status", st, 32'h0000_0002);
    tick();
    chk("reset_tx_idle", {31'b0, tx}, 32'h1);

    // Single byte
    mem_address = BASE; mem_write_data = 32'h0000_01A5; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; mem_address = 32'h0;
    chk("single_tx_edge_k", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("single_status_queued", st, 32'h0000_0100);
    wave = '0; wn = 0;
    run(40);
    chk_wave("single_frame", 40, {216'b0, frame(8'hA5)});
    read_status(st);
    chk("single_busy_in_stop", st, 32'h0000_0006);
    tick();
    read_status(st);
    chk("single_idle_after", st, 32'h0000_0002);

    // Back-to-back
    wave = '0; wn = 0;
    mem_address = BASE; mem_write_data = 32'h55; mem_write = 1'b1;
    tick();
    mem_write_data = 32'h0F;
    run(1);
    mem_write = 1'b0; mem_address = 32'h0;
    run(9);
    read_status(st);
    chk("b2b_count_first_frame", st, 32'h0000_0104);
    run(70);
    chk_wave("b2b_frames", 80, {176'b0, frame(8'h0F), frame(8'h55)});
    tick();
    chk("b2b_tx_idle", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("b2b_status_idle", st, 32'h0000_0002);

    // Overflow: six writes from idle, FIFO depth 4
    wave = '0; wn = 0;
    mem_address = BASE; mem_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_write_data = 32'((i + 1) * 8'h11);
      if (i == 0) tick();
      else run(1);
    end
    mem_write = 1'b0; mem_address = 32'h0;
    read_status(st);
    chk("ovf_status_full", st, 32'h0000_040D);
    mem_address = BASE + 32'd4; mem_write_data = 32'h0; mem_write = 1'b1;
    run(1);
    mem_write = 1'b0; mem_address = 32'h0;
    read_status(st);
    chk("ovf_cleared", st, 32'h0000_0405);
    run(194);
    exp_w = '0;
    exp_w[199:0] = {frame(8'h55), frame(8'h44), frame(8'h33), frame(8'h22), frame(8'h11)};
    chk_wave("ovf_five_frames", 200, exp_w);
    tick();
    read_status(st);
    chk("ovf_idle_after", st, 32'h0000_0002);
    wave = '0; wn = 0;
    run(40);
    chk_wave("ovf_no_sixth_frame", 40, {216'b0, {40{1'b1}}});

    // Mid-frame reset with two bytes queued
    mem_address = BASE; mem_write = 1'b1;
    mem_write_data = 32'hF0; tick();
    mem_write_data = 32'h81; tick();
    mem_write_data = 32'h7E; tick();
    mem_write = 1'b0; mem_address = 32'h0;
    read_status(st);
    chk("midrst_queued", st, 32'h0000_0204);
    for (int i = 0; i < 16; i++) tick();
    chk("midrst_bit3_low", {31'b0, tx}, 32'h0);
    rst = 1'b0;
    tick();
    chk("midrst_tx_high", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("midrst_status", st, 32'h0000_0002);
    rst = 1'b1;
    wave = '0; wn = 0;
    run(50);
    chk_wave("midrst_no_frames", 50, {206'b0, {50{1'b1}}});

    // Decode
    mem_address = BASE + 32'd8;
    #1;
    chk("dec_hit_out", {31'b0, hit}, 32'h0);
    chk("dec_rdata_out", read_data, 32'h0);
    mem_address = BASE;
    #1;
    chk("dec_hit_txdata", {31'b0, hit}, 32'h1);
    chk("dec_rdata_txdata", read_data, 32'h0);
    mem_address = BASE + 32'd4;
    #1;
    chk("dec_hit_status", {31'b0, hit}, 32'h1);
    mem_address = BASE + 32'd8; mem_write_data = 32'h99; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; mem_address = 32'h0;
    read_status(st);
    chk("dec_write_ignored", st, 32'h0000_0002);
    wave = '0; wn = 0;
    run(8);
    chk_wave("dec_tx_quiet", 8, {248'b0, 8'hFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
